axi_lite_regfile: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_regfile_wpath.sv | 99 +++++++++
 rtl/axi_lite_regfile.sv | 126 ++++++++++++
 tb/tb_axi_lite_regfile.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite register-file types: response codes and address decode helpers.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Register index of a byte address; only meaningful when in_range() holds.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // Word-aligned and below the register count.
  function automatic logic in_range(input logic [63:0] addr, input int unsigned lsb,
                                    input int unsigned num_regs);
    logic [63:0] mask;
    mask = (64'(1) << lsb) - 64'(1);
    return ((addr & mask) == 64'(0)) && ((addr >> lsb) < 64'(num_regs));
  endfunction

endpackage

// File: rtl/axi_lite_regfile_wpath.sv
// AXI-Lite write path: independent AW/W capture, commit strobe toward the
// register array, and the B response channel.
module axi_lite_regfile_wpath
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_WIDTH-1:0]                 aw_addr,
  input  logic                                  aw_valid,
  output logic                                  aw_ready,
  input  logic [DATA_WIDTH-1:0]                 w_data,
  input  logic [DATA_WIDTH/8-1:0]               w_strb,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  output resp_t                                 b_resp,
  output logic                                  b_valid,
  input  logic                                  b_ready,
  output logic                                  wr_en_c,
  output logic [(NUM_REGS > 1 ? $clog2(NUM_REGS) : 1)-1:0] wr_idx_c,
  output logic [DATA_WIDTH-1:0]                 wr_data_c,
  output logic [DATA_WIDTH/8-1:0]               wr_strb_c
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  aw_held, aw_held_n;
  logic                  w_held, w_held_n;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  b_valid_n, aw_ready_n, w_ready_n;
  resp_t                 b_resp_n;
  logic                  aw_fire, w_fire, commit, addr_ok;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // The commit uses whichever of held/live beat is available this cycle.
  always_comb begin
    aw_fire   = aw_valid && aw_ready;
    w_fire    = w_valid && w_ready;
    cur_addr  = aw_held ? aw_addr_q : aw_addr;
    wr_data_c = w_held ? w_data_q : w_data;
    wr_strb_c = w_held ? w_strb_q : w_strb;
    commit    = (aw_held || aw_fire) && (w_held || w_fire);
    addr_ok   = in_range(64'(cur_addr), LSB, NUM_REGS);
    wr_idx_c  = IDX_W'(addr_to_idx(64'(cur_addr), LSB));
    wr_en_c   = commit && addr_ok && !RO_MASK[wr_idx_c];

    aw_held_n = aw_held;
    w_held_n  = w_held;
    b_valid_n = b_valid;
    b_resp_n  = b_resp;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      b_valid_n = 1'b1;
      b_resp_n  = addr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_fire) aw_held_n = 1'b1;
      if (w_fire) w_held_n = 1'b1;
      if (b_valid && b_ready) b_valid_n = 1'b0;
    end
    aw_ready_n = !aw_held_n && !b_valid_n;
    w_ready_n  = !w_held_n && !b_valid_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
      aw_ready  <= 1'b1;
      w_ready   <= 1'b1;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held  <= aw_held_n;
      w_held   <= w_held_n;
      b_valid  <= b_valid_n;
      b_resp   <= b_resp_n;
      aw_ready <= aw_ready_n;
      w_ready  <= w_ready_n;
      if (aw_fire) aw_addr_q <= aw_addr;
      if (w_fire) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI-Lite slave register file: RW register array with byte
// strobes, read-only slots mirroring HW_IN, and a single-outstanding read path.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           A_CLK,
  input  logic                           A_RESET,
  input  logic [ADDR_WIDTH-1:0]          AW_ADDR,
  input  logic                           AW_VALID,
  output logic                           AW_READY,
  input  logic [DATA_WIDTH-1:0]          W_DATA,
  input  logic [DATA_WIDTH/8-1:0]        W_STRB,
  input  logic                           W_VALID,
  output logic                           W_READY,
  output logic [1:0]                     B_RESP,
  output logic                           B_VALID,
  input  logic                           B_READY,
  input  logic [ADDR_WIDTH-1:0]          AR_ADDR,
  input  logic                           AR_VALID,
  output logic                           AR_READY,
  output logic [DATA_WIDTH-1:0]          R_DATA,
  output logic [1:0]                     R_RESP,
  output logic                           R_VALID,
  input  logic                           R_READY,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] HW_IN,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_O
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw   [NUM_REGS];

  logic                  wr_en_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  resp_t                 b_resp;
  resp_t                 r_resp;

  axi_lite_regfile_wpath #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wpath (
    .clk       (A_CLK),
    .reset     (A_RESET),
    .aw_addr   (AW_ADDR),
    .aw_valid  (AW_VALID),
    .aw_ready  (AW_READY),
    .w_data    (W_DATA),
    .w_strb    (W_STRB),
    .w_valid   (W_VALID),
    .w_ready   (W_READY),
    .b_resp    (b_resp),
    .b_valid   (B_VALID),
    .b_ready   (B_READY),
    .wr_en_c   (wr_en_c),
    .wr_idx_c  (wr_idx_c),
    .wr_data_c (wr_data_c),
    .wr_strb_c (wr_strb_c)
  );

  assign B_RESP = b_resp;
  assign R_RESP = r_resp;

  // Per-register views of the status bus and the RW contents export.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slice
    assign hw[g] = HW_IN[g*DATA_WIDTH +: DATA_WIDTH];
    assign REGS_O[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
  end

  // Register array; read-only slots are never written.
  always_ff @(posedge A_CLK) begin
    if (A_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_en_c && wr_idx_c == IDX_W'(i) && wr_strb_c[b])
            regs[i][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  logic                  ar_fire, rd_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    ar_fire = AR_VALID && AR_READY;
    rd_ok   = in_range(64'(AR_ADDR), LSB, NUM_REGS);
    rd_idx  = IDX_W'(addr_to_idx(64'(AR_ADDR), LSB));
    rd_val  = '0;
    if (rd_ok) rd_val = RO_MASK[rd_idx] ? hw[rd_idx] : regs[rd_idx];
  end

  // Read channel; the array is sampled before any same-edge write lands.
  always_ff @(posedge A_CLK) begin
    if (A_RESET) begin
      R_VALID  <= 1'b0;
      AR_READY <= 1'b1;
      R_DATA   <= '0;
      r_resp   <= RESP_OKAY;
    end else if (ar_fire) begin
      R_VALID  <= 1'b1;
      AR_READY <= 1'b0;
      R_DATA   <= rd_val;
      r_resp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (R_VALID && R_READY) begin
      R_VALID  <= 1'b0;
      AR_READY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus random
// traffic compared against an array-based model of the register map.
module tb_axi_lite_regfile;

  localparam int unsigned NR = 8;
  localparam int unsigned DW = 32;
  localparam logic [NR-1:0] RO = 8'b0000_1000;

  function automatic logic [NR*DW-1:0] mk_reset();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = 32'h5A5A_0000 | 32'(i * 17 + 1);
    return v;
  endfunction
  localparam logic [NR*DW-1:0] RV = mk_reset();

  logic           A_CLK, A_RESET;
  logic [31:0]    AW_ADDR, AR_ADDR, W_DATA, R_DATA;
  logic [3:0]     W_STRB;
  logic           AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic           AR_VALID, AR_READY, R_VALID, R_READY;
  logic [1:0]     B_RESP, R_RESP;
  logic [NR*DW-1:0] hw_bus, REGS_O;

  axi_lite_regfile #(
    .ADDR_WIDTH (32), .DATA_WIDTH (DW), .NUM_REGS (NR), .RO_MASK (RO), .RESET_VAL (RV)
  ) dut (
    .A_CLK (A_CLK), .A_RESET (A_RESET),
    .AW_ADDR (AW_ADDR), .AW_VALID (AW_VALID), .AW_READY (AW_READY),
    .W_DATA (W_DATA), .W_STRB (W_STRB), .W_VALID (W_VALID), .W_READY (W_READY),
    .B_RESP (B_RESP), .B_VALID (B_VALID), .B_READY (B_READY),
    .AR_ADDR (AR_ADDR), .AR_VALID (AR_VALID), .AR_READY (AR_READY),
    .R_DATA (R_DATA), .R_RESP (R_RESP), .R_VALID (R_VALID), .R_READY (R_READY),
    .HW_IN (hw_bus), .REGS_O (REGS_O)
  );

  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [NR];

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_ok(input logic [31:0] addr);
    return (addr % 4 == 0) && (addr / 4 < NR);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
  endtask

  task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr / 4);
    if (m_ok(addr) && !RO[idx])
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic m_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr / 4);
    d = 32'h0;
    r = 2'b10;
    if (m_ok(addr)) begin
      r = 2'b00;
      d = RO[idx] ? hw_bus[idx*DW +: DW] : model[idx];
    end
  endtask

  function automatic logic [NR*DW-1:0] m_regs();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? 32'h0 : model[i];
    return v;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int extra);
    bit aw_done, w_done, aw_f, w_f;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    AW_ADDR = addr; W_DATA = data; W_STRB = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      AW_VALID = !aw_done && (cyc >= aw_dly);
      W_VALID  = !w_done && (cyc >= w_dly);
      aw_f = AW_VALID && AW_READY;
      w_f  = W_VALID && W_READY;
      tick();
      cyc++;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
    end
    AW_VALID = 0; W_VALID = 0;
    extra = 0;
    while (!B_VALID && extra < 20) begin tick(); extra++; end
    resp = B_RESP;
    repeat (b_dly) tick();
    B_READY = 1;
    tick();
    B_READY = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp, output int extra);
    bit f;
    int cyc;
    f = 0; cyc = 0;
    AR_ADDR = addr; AR_VALID = 1;
    while (!f && cyc < 60) begin
      f = AR_READY;
      tick();
      cyc++;
    end
    AR_VALID = 0;
    extra = 0;
    while (!R_VALID && extra < 20) begin tick(); extra++; end
    data = R_DATA; resp = R_RESP;
    repeat (r_dly) tick();
    R_READY = 1;
    tick();
    R_READY = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int ex;
    A_RESET = 1;
    tick(); tick();
    A_RESET = 0;
    m_reset();
    n_checks++; if (AW_READY !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready got %b exp 1", AW_READY); end
    n_checks++; if (W_READY !== 1'b1) begin n_fail++; $display("FAIL reset_w_ready got %b exp 1", W_READY); end
    n_checks++; if (AR_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ar_ready got %b exp 1", AR_READY); end
    n_checks++; if (B_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %b exp 0", B_VALID); end
    n_checks++; if (R_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid got %b exp 0", R_VALID); end
    n_checks++; if (B_RESP !== 2'b00 || R_RESP !== 2'b00) begin n_fail++; $display("FAIL reset_resp got %b/%b exp 00/00", B_RESP, R_RESP); end
    n_checks++; if (R_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_r_data got %h exp 0", R_DATA); end
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL reset_regs got %h exp %h", REGS_O, m_regs()); end
    do_read(32'h0, 0, d, r, ex);
    n_checks++; if (d !== RV[31:0] || r !== 2'b00) begin n_fail++; $display("FAIL reset_read0 got %h/%b exp %h/00", d, r, RV[31:0]); end
    n_checks++; if (ex !== 0) begin n_fail++; $display("FAIL reset_read0_latency got %0d extra exp 0", ex); end
  endtask

  task automatic test_gap_write();
    logic [31:0] d; logic [1:0] r; int ex;
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, r, ex);
    m_write(32'h04, 32'hDEAD_BEEF, 4'hF);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL gap_aw_first_resp got %b exp 00", r); end
    n_checks++; if (ex !== 0) begin n_fail++; $display("FAIL gap_aw_first_latency got %0d extra exp 0", ex); end
    n_checks++; if (B_VALID !== 1'b0) begin n_fail++; $display("FAIL gap_b_release got %b exp 0", B_VALID); end
    do_read(32'h04, 1, d, r, ex);
    n_checks++; if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin n_fail++; $display("FAIL gap_readback got %h/%b exp deadbeef/00", d, r); end
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, 2, 0, 1, r, ex);
    m_write(32'h14, 32'h0BAD_F00D, 4'hF);
    n_checks++; if (ex !== 0 || r !== 2'b00) begin n_fail++; $display("FAIL gap_w_first got extra %0d resp %b exp 0/00", ex, r); end
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL gap_regs got %h exp %h", REGS_O, m_regs()); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int ex;
    do_write(32'h08, 32'h1122_3344, 4'hF, 0, 0, 0, r, ex);
    do_write(32'h08, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, r, ex);
    do_read(32'h08, 0, d, r, ex);
    n_checks++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_merge got %h exp 11bb33dd", d); end
    m_write(32'h08, 32'h1122_3344, 4'hF);
    m_write(32'h08, 32'hAABB_CCDD, 4'b0101);
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int ex;
    do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, ex);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_idx8_bresp got %b exp 10", r); end
    do_write(32'h05, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, r, ex);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_misaligned_bresp got %b exp 10", r); end
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL oor_regs_changed got %h exp %h", REGS_O, m_regs()); end
    do_read(32'h20, 0, d, r, ex);
    n_checks++; if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL oor_read got %h/%b exp 0/10", d, r); end
  endtask

  task automatic test_read_only();
    logic [31:0] d; logic [1:0] r; int ex;
    hw_bus[3*DW +: DW] = 32'hCAFE_0001;
    do_write(32'h0C, 32'h0, 4'hF, 0, 0, 0, r, ex);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL ro_write_resp got %b exp 00", r); end
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL ro_regs got %h exp %h", REGS_O, m_regs()); end
    do_read(32'h0C, 0, d, r, ex);
    n_checks++; if (d !== 32'hCAFE_0001 || r !== 2'b00) begin n_fail++; $display("FAIL ro_read got %h/%b exp cafe0001/00", d, r); end
  endtask

  task automatic test_same_edge();
    logic [31:0] oldv;
    oldv = model[1];
    AW_ADDR = 32'h04; AW_VALID = 1;
    tick();
    AW_VALID = 0;
    W_DATA = 32'h7777_1234; W_STRB = 4'hF; W_VALID = 1;
    AR_ADDR = 32'h04; AR_VALID = 1;
    tick();
    W_VALID = 0; AR_VALID = 0;
    n_checks++; if (B_VALID !== 1'b1 || B_RESP !== 2'b00) begin n_fail++; $display("FAIL same_edge_b got %b/%b exp 1/00", B_VALID, B_RESP); end
    n_checks++; if (R_VALID !== 1'b1 || R_DATA !== oldv) begin n_fail++; $display("FAIL same_edge_old_value got %b/%h exp 1/%h", R_VALID, R_DATA, oldv); end
    B_READY = 1; R_READY = 1;
    tick();
    B_READY = 0; R_READY = 0;
    m_write(32'h04, 32'h7777_1234, 4'hF);
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL same_edge_regs got %h exp %h", REGS_O, m_regs()); end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, d, ed; logic [3:0] strb; logic [1:0] r, er; int ex;
    for (int it = 0; it < 60; it++) begin
      addr = 32'($urandom_range(0, 9) * 4);
      if ($urandom_range(0, 4) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) hw_bus[3*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), r, ex);
        er = m_ok(addr) ? 2'b00 : 2'b10;
        m_write(addr, data, strb);
        n_checks++; if (r !== er || ex !== 0) begin n_fail++; $display("FAIL rand_write a=%h got %b/%0d exp %b/0", addr, r, ex, er); end
        n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL rand_regs a=%h got %h exp %h", addr, REGS_O, m_regs()); end
      end else begin
        m_read(addr, ed, er);
        do_read(addr, $urandom_range(0, 2), d, r, ex);
        n_checks++; if (d !== ed || r !== er || ex !== 0) begin n_fail++; $display("FAIL rand_read a=%h got %h/%b/%0d exp %h/%b/0", addr, d, r, ex, ed, er); end
      end
    end
  endtask

  task automatic test_b_stall_reset();
    AW_ADDR = 32'h18; AW_VALID = 1;
    W_DATA = 32'h1357_9BDF; W_STRB = 4'hF; W_VALID = 1;
    AR_ADDR = 32'h18; AR_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (B_VALID !== 1'b1 || B_RESP !== 2'b00) begin n_fail++; $display("FAIL stall_b_hold cyc %0d got %b/%b exp 1/00", k, B_VALID, B_RESP); end
      n_checks++; if (AW_READY !== 1'b0 || W_READY !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc %0d got %b/%b exp 0/0", k, AW_READY, W_READY); end
      tick();
    end
    n_checks++; if (R_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_r_pending got %b exp 1", R_VALID); end
    A_RESET = 1;
    tick();
    A_RESET = 0;
    m_reset();
    n_checks++; if (B_VALID !== 1'b0 || R_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_mid_txn got %b/%b exp 0/0", B_VALID, R_VALID); end
    n_checks++; if (AW_READY !== 1'b1 || W_READY !== 1'b1 || AR_READY !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready got %b%b%b exp 111", AW_READY, W_READY, AR_READY); end
    n_checks++; if (REGS_O !== m_regs()) begin n_fail++; $display("FAIL reset_mid_regs got %h exp %h", REGS_O, m_regs()); end
  endtask

  initial begin
    A_RESET = 1;
    AW_ADDR = '0; AW_VALID = 0; W_DATA = '0; W_STRB = '0; W_VALID = 0; B_READY = 0;
    AR_ADDR = '0; AR_VALID = 0; R_READY = 0;
    for (int i = 0; i < NR; i++) hw_bus[i*DW +: DW] = $urandom;
    test_reset();
    test_gap_write();
    test_strobe();
    test_out_of_range();
    test_read_only();
    test_same_edge();
    test_random();
    test_b_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
